// File: rtl/ysyx_22041071_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings,
// bus response codes and the access-size to byte-strobe helper.
package ysyx_22041071_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // One strobe bit per byte of a 2^size-byte access, LSB-aligned.
    function automatic logic [7:0] size_to_strb(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041071_lsu_align.sv
// Combinational data path of the LSU: load lane extraction with sign/zero extension,
// store lane shift and strobe generation, and the misaligned/illegal access check.
module ysyx_22041071_lsu_align
    import ysyx_22041071_lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]          funct3_i,
    input  logic                is_load_i,
    input  logic [2:0]          addr_lo_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W-1:0]   load_data_o,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W/8-1:0] w_strb_o,
    output logic                err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    logic [LANE_W-1:0] lane;
    logic [LANE_W+2:0] shamt;
    logic [1:0]        size;
    logic [DATA_W-1:0] rshift;
    logic              misaligned;
    logic              illegal;

    assign lane   = addr_lo_i[LANE_W-1:0];
    assign shamt  = {lane, 3'b000};
    assign size   = funct3_i[1:0];
    assign rshift = rdata_i >> shamt;

    // Doubleword and unsigned-word loads do not exist on a 32-bit datapath.
    assign illegal = (funct3_i == F3_BAD) ||
                     ((DATA_W == 32) && ((funct3_i == F3_LD) || (is_load_i && funct3_i == F3_LWU)));

    // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd1:    misaligned = addr_lo_i[0];
            2'd2:    misaligned = |addr_lo_i[1:0];
            2'd3:    misaligned = |addr_lo_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign err_o = misaligned || illegal;

    always_comb begin
        load_data_o = rshift;
        case (funct3_i)
            F3_LB:   load_data_o = DATA_W'($signed(rshift[7:0]));
            F3_LH:   load_data_o = DATA_W'($signed(rshift[15:0]));
            F3_LW:   load_data_o = DATA_W'($signed(rshift[31:0]));
            F3_LBU:  load_data_o = DATA_W'(rshift[7:0]);
            F3_LHU:  load_data_o = DATA_W'(rshift[15:0]);
            F3_LWU:  load_data_o = DATA_W'(rshift[31:0]);
            default: load_data_o = rshift;
        endcase
    end

    assign w_data_o = wdata_i << shamt;
    assign w_strb_o = STRB_W'(size_to_strb(size)) << lane;

endmodule

// File: rtl/ysyx_22041071_lsu.sv
// Load/store unit between EX and WB: one outstanding AXI-style read or write,
// result delivered through a registered valid/ready output slot.
module ysyx_22041071_lsu
    import ysyx_22041071_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int RESP_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_pc,
    input  logic [31:0]         in_ins,
    input  logic                in_mem_rd,
    input  logic                in_mem_wr,
    input  logic                in_reg_w_en,
    input  logic [4:0]          in_rdest,
    input  logic [DATA_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [ADDR_W-1:0]   ar_addr,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [RESP_W-1:0]   r_resp,
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [ADDR_W-1:0]   aw_addr,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [RESP_W-1:0]   b_resp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [31:0]         out_ins,
    output logic                out_reg_w_en,
    output logic [4:0]          out_rdest,
    output logic [DATA_W-1:0]   out_wb_data,
    output logic                out_err
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       ins;
        logic              reg_w_en;
        logic [4:0]        rdest;
        logic [DATA_W-1:0] wb_data;
        logic              err;
    } slot_t;

    lsu_state_e        state_q, state_d;
    slot_t             slot_q, slot_d;
    logic              out_valid_q, out_valid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              started_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ins_q;
    logic              reg_w_en_q;
    logic [4:0]        rdest_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              idle, slot_free, accept, req_load, r_err, b_err;
    logic [2:0]        al_funct3;
    logic [2:0]        al_addr_lo;
    logic [DATA_W-1:0] al_load_data, al_w_data;
    logic [DATA_W/8-1:0] al_w_strb;
    logic              al_err;

    assign idle      = (state_q == S_IDLE);
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = started_q && idle && slot_free;
    assign accept    = in_valid && in_ready;
    assign req_load  = in_mem_rd && !in_mem_wr;
    assign r_err     = (r_resp != RESP_W'(RESP_OKAY));
    assign b_err     = (b_resp != RESP_W'(RESP_OKAY));

    // In IDLE the aligner checks the incoming request; otherwise it serves the latched one.
    assign al_funct3  = idle ? in_ins[14:12] : ins_q[14:12];
    assign al_addr_lo = idle ? in_addr[2:0]  : addr_q[2:0];

    ysyx_22041071_lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i    (al_funct3),
        .is_load_i   (req_load),
        .addr_lo_i   (al_addr_lo),
        .wdata_i     (wdata_q),
        .rdata_i     (r_data),
        .load_data_o (al_load_data),
        .w_data_o    (al_w_data),
        .w_strb_o    (al_w_strb),
        .err_o       (al_err)
    );

    assign ar_valid = (state_q == S_RD_ADDR);
    assign ar_addr  = ar_valid ? ADDR_W'(addr_q) : '0;
    assign r_ready  = (state_q == S_RD_DATA) && slot_free;
    assign aw_valid = (state_q == S_WR_REQ) && !aw_done_q;
    assign aw_addr  = aw_valid ? ADDR_W'(addr_q) : '0;
    assign w_valid  = (state_q == S_WR_REQ) && !w_done_q;
    assign w_data   = w_valid ? al_w_data : '0;
    assign w_strb   = w_valid ? al_w_strb : '0;
    assign b_ready  = (state_q == S_WR_RESP) && slot_free;

    assign out_valid    = out_valid_q;
    assign out_pc       = slot_q.pc;
    assign out_ins      = slot_q.ins;
    assign out_reg_w_en = slot_q.reg_w_en;
    assign out_rdest    = slot_q.rdest;
    assign out_wb_data  = slot_q.wb_data;
    assign out_err      = slot_q.err;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        out_valid_d = out_valid_q && !out_ready;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (!in_mem_rd && !in_mem_wr) begin
                        out_valid_d = 1'b1;
                        slot_d      = '{pc: in_pc, ins: in_ins, reg_w_en: in_reg_w_en,
                                        rdest: in_rdest, wb_data: in_addr, err: 1'b0};
                    end else if (al_err) begin
                        out_valid_d = 1'b1;
                        slot_d      = '{pc: in_pc, ins: in_ins, reg_w_en: 1'b0,
                                        rdest: in_rdest, wb_data: '0, err: 1'b1};
                    end else if (in_mem_wr) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (ar_ready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (r_valid && r_ready) begin
                    out_valid_d = 1'b1;
                    slot_d      = '{pc: pc_q, ins: ins_q, reg_w_en: reg_w_en_q && !r_err,
                                    rdest: rdest_q, wb_data: al_load_data, err: r_err};
                    state_d     = S_IDLE;
                end
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q || aw_ready;
                w_done_d  = w_done_q || w_ready;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (b_valid && b_ready) begin
                    out_valid_d = 1'b1;
                    slot_d      = '{pc: pc_q, ins: ins_q, reg_w_en: 1'b0,
                                    rdest: rdest_q, wb_data: '0, err: b_err};
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            started_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            ins_q      <= '0;
            reg_w_en_q <= 1'b0;
            rdest_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            pc_q       <= in_pc;
            ins_q      <= in_ins;
            reg_w_en_q <= in_reg_w_en;
            rdest_q    <= in_rdest;
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_lsu.sv
// Directed self-checking bench for the LSU: a 64-bit instance carries the main sequence,
// a 32-bit instance covers the narrow-datapath width rules.
module tb_ysyx_22041071_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        reset;
    // 64-bit instance
    logic        in_valid, in_ready, in_mem_rd, in_mem_wr, in_reg_w_en;
    logic [63:0] in_pc, in_addr, in_wdata;
    logic [31:0] in_ins;
    logic [4:0]  in_rdest;
    logic        ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready;
    logic        w_valid, w_ready, b_valid, b_ready;
    logic [63:0] ar_addr, aw_addr, r_data, w_data;
    logic [1:0]  r_resp, b_resp;
    logic [7:0]  w_strb;
    logic        out_valid, out_ready, out_reg_w_en, out_err;
    logic [63:0] out_pc, out_wb_data;
    logic [31:0] out_ins;
    logic [4:0]  out_rdest;
    // 32-bit instance
    logic        s_in_valid, s_in_ready, s_in_mem_rd, s_in_mem_wr, s_in_reg_w_en;
    logic [31:0] s_in_pc, s_in_addr, s_in_wdata, s_in_ins;
    logic [4:0]  s_in_rdest;
    logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_aw_valid, s_aw_ready;
    logic        s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [31:0] s_ar_addr, s_aw_addr, s_r_data, s_w_data;
    logic [1:0]  s_r_resp, s_b_resp;
    logic [3:0]  s_w_strb;
    logic        s_out_valid, s_out_ready, s_out_reg_w_en, s_out_err;
    logic [31:0] s_out_pc, s_out_wb_data, s_out_ins;
    logic [4:0]  s_out_rdest;

    ysyx_22041071_lsu #(.DATA_W(64), .ADDR_W(64), .RESP_W(2)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_reg_w_en(in_reg_w_en),
        .in_rdest(in_rdest), .in_addr(in_addr), .in_wdata(in_wdata),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
        .out_reg_w_en(out_reg_w_en), .out_rdest(out_rdest),
        .out_wb_data(out_wb_data), .out_err(out_err)
    );

    ysyx_22041071_lsu #(.DATA_W(32), .ADDR_W(32), .RESP_W(2)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc), .in_ins(s_in_ins),
        .in_mem_rd(s_in_mem_rd), .in_mem_wr(s_in_mem_wr), .in_reg_w_en(s_in_reg_w_en),
        .in_rdest(s_in_rdest), .in_addr(s_in_addr), .in_wdata(s_in_wdata),
        .ar_valid(s_ar_valid), .ar_ready(s_ar_ready), .ar_addr(s_ar_addr),
        .r_valid(s_r_valid), .r_ready(s_r_ready), .r_data(s_r_data), .r_resp(s_r_resp),
        .aw_valid(s_aw_valid), .aw_ready(s_aw_ready), .aw_addr(s_aw_addr),
        .w_valid(s_w_valid), .w_ready(s_w_ready), .w_data(s_w_data), .w_strb(s_w_strb),
        .b_valid(s_b_valid), .b_ready(s_b_ready), .b_resp(s_b_resp),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc), .out_ins(s_out_ins),
        .out_reg_w_en(s_out_reg_w_en), .out_rdest(s_out_rdest),
        .out_wb_data(s_out_wb_data), .out_err(s_out_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata);
        in_valid    = 1'b1;
        in_mem_rd   = rd;
        in_mem_wr   = wr;
        in_ins      = 32'h0000_0003 | (32'(f3) << 12);
        in_addr     = addr;
        in_wdata    = wdata;
        in_reg_w_en = 1'b1;
        in_rdest    = 5'd7;
        in_pc       = in_pc + 64'd4;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 0; in_mem_rd = 0; in_mem_wr = 0; in_reg_w_en = 0; in_pc = 64'h1000;
        in_addr = 0; in_wdata = 0; in_ins = 0; in_rdest = 0;
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; out_ready = 1;
        s_in_valid = 0; s_in_mem_rd = 0; s_in_mem_wr = 0; s_in_reg_w_en = 0; s_in_pc = 0;
        s_in_addr = 0; s_in_wdata = 0; s_in_ins = 0; s_in_rdest = 0;
        s_ar_ready = 1; s_r_valid = 1; s_r_data = 0; s_r_resp = 0;
        s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = 0; s_out_ready = 1;

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_aw_w_valid", {aw_valid, w_valid}, 0);
        check("rst_w_strb", w_strb, 0);
        check("rst_r_b_ready", {r_ready, b_ready}, 0);
        tick(); tick();
        reset = 1'b1;
        #1 check("in_ready_before_edge", in_ready, 0);
        tick();
        check("in_ready_after_edge", in_ready, 1);

        // Pass-through, back to back
        req(0, 0, 3'b000, 64'h1234_5678_9ABC_DEF0, 0);
        tick();
        check("pt_out_valid", out_valid, 1);
        check("pt_wb", out_wb_data, 64'h1234_5678_9ABC_DEF0);
        check("pt_err", out_err, 0);
        check("pt_rdest", out_rdest, 7);
        check("pt_reg_w_en", out_reg_w_en, 1);
        check("pt_in_ready", in_ready, 1);
        in_addr = 64'h0BAD_F00D;
        tick();
        check("pt2_out_valid", out_valid, 1);
        check("pt2_wb", out_wb_data, 64'h0BAD_F00D);
        in_valid = 0;
        tick();
        check("pt_drained", out_valid, 0);

        // lb at 0x8000_0003: byte 0x80 sign-extended
        req(1, 0, 3'b000, 64'h8000_0003, 0);
        ar_ready = 1; r_valid = 1; r_data = 64'h0000_0000_80FF_0000; r_resp = 0;
        tick();
        check("lb_ar_valid", ar_valid, 1);
        check("lb_ar_addr", ar_addr, 64'h8000_0003);
        check("lb_no_early_out", out_valid, 0);
        in_valid = 0;
        tick();
        check("lb_ar_done", ar_valid, 0);
        check("lb_r_ready", r_ready, 1);
        tick();
        check("lb_out_valid", out_valid, 1);
        check("lb_wb", out_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_err", out_err, 0);
        check("lb_reg_w_en", out_reg_w_en, 1);
        ar_ready = 0; r_valid = 0;
        tick();

        // sh at 0x8000_0006, aw_ready lags w_ready by 3 cycles
        req(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h1234);
        w_ready = 1; aw_ready = 0;
        tick();
        check("sh_aw_valid", aw_valid, 1);
        check("sh_w_valid", w_valid, 1);
        check("sh_aw_addr", aw_addr, 64'h8000_0006);
        check("sh_w_data", w_data, 64'h1234_0000_0000_0000);
        check("sh_w_strb", w_strb, 8'hC0);
        in_valid = 0;
        tick();
        check("sh_w_done", w_valid, 0);
        check("sh_aw_held", aw_valid, 1);
        tick(); tick();
        check("sh_aw_still_held", aw_valid, 1);
        aw_ready = 1;
        tick();
        check("sh_aw_done", aw_valid, 0);
        check("sh_b_ready", b_ready, 1);
        check("sh_no_early_out", out_valid, 0);
        b_valid = 1; b_resp = 0; aw_ready = 0; w_ready = 0;
        tick();
        check("sh_out_valid", out_valid, 1);
        check("sh_reg_w_en", out_reg_w_en, 0);
        check("sh_err", out_err, 0);
        check("sh_wb", out_wb_data, 0);
        b_valid = 0;
        tick();
        check("sh_single_completion", out_valid, 0);
        check("sh_idle", in_ready, 1);

        // lw at 0x8000_0002: misaligned, no bus access
        req(1, 0, 3'b010, 64'h8000_0002, 0);
        tick();
        check("mis_no_ar", ar_valid, 0);
        check("mis_out_valid", out_valid, 1);
        check("mis_err", out_err, 1);
        check("mis_reg_w_en", out_reg_w_en, 0);
        check("mis_wb", out_wb_data, 0);
        in_valid = 0;
        tick();

        // ld with SLVERR, then a clean pass-through
        req(1, 0, 3'b011, 64'h8000_0008, 0);
        ar_ready = 1; r_valid = 1; r_data = 64'hDEAD; r_resp = 2'b10;
        tick();
        in_valid = 0;
        tick(); tick();
        check("rerr_out_valid", out_valid, 1);
        check("rerr_err", out_err, 1);
        check("rerr_reg_w_en", out_reg_w_en, 0);
        ar_ready = 0; r_valid = 0; r_resp = 0;
        req(0, 0, 3'b000, 64'h55, 0);
        tick();
        check("after_err_err", out_err, 0);
        check("after_err_reg_w_en", out_reg_w_en, 1);
        check("after_err_wb", out_wb_data, 64'h55);
        in_valid = 0;
        tick();

        // Downstream stall: pass-through held, load pending at the input
        out_ready = 0;
        req(0, 0, 3'b000, 64'hAAAA, 0);
        tick();
        check("stall_pt_valid", out_valid, 1);
        req(1, 0, 3'b011, 64'h8000_0010, 0);
        ar_ready = 1; r_valid = 1; r_data = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_ar_valid", ar_valid, 0);
            check("stall_r_ready", r_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_wb", out_wb_data, 64'hAAAA);
            tick();
        end
        out_ready = 1;
        #1 check("release_in_ready", in_ready, 1);
        tick();
        check("release_drained", out_valid, 0);
        check("release_ar_valid", ar_valid, 1);
        in_valid = 0;
        tick();
        check("release_r_ready", r_ready, 1);
        tick();
        check("release_ld_valid", out_valid, 1);
        check("release_ld_wb", out_wb_data, 64'h1122_3344_5566_7788);
        ar_ready = 0; r_valid = 0;
        tick();

        // Reset pulsed while in RD_DATA
        req(1, 0, 3'b011, 64'h8000_0018, 0);
        ar_ready = 1; r_valid = 0;
        tick();
        in_valid = 0;
        tick();
        check("prerst_r_ready", r_ready, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_ar_valid", ar_valid, 0);
        check("midrst_r_ready", r_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        ar_ready = 0;
        tick(); tick();
        reset = 1'b1;
        #1 check("postrst_in_ready_wait", in_ready, 0);
        tick();
        check("postrst_in_ready", in_ready, 1);
        req(1, 0, 3'b011, 64'h8000_0010, 0);
        ar_ready = 1; r_valid = 1; r_data = 64'h0102_0304_0506_0708;
        tick();
        check("postrst_ar_valid", ar_valid, 1);
        check("postrst_ar_addr", ar_addr, 64'h8000_0010);
        in_valid = 0;
        tick();
        check("postrst_not_early", out_valid, 0);
        tick();
        check("postrst_out_valid", out_valid, 1);
        check("postrst_wb", out_wb_data, 64'h0102_0304_0506_0708);
        check("postrst_err", out_err, 0);
        ar_ready = 0; r_valid = 0;
        tick();

        // 32-bit datapath: ld is illegal, lh extends to 32 bits
        s_in_valid = 1; s_in_mem_rd = 1; s_in_reg_w_en = 1; s_in_rdest = 5'd3;
        s_in_ins = 32'h0000_3003; s_in_addr = 32'h8000_0000;
        tick();
        check("w32_ld_out_valid", s_out_valid, 1);
        check("w32_ld_err", s_out_err, 1);
        check("w32_ld_no_ar", s_ar_valid, 0);
        s_in_ins = 32'h0000_1003; s_in_addr = 32'h8000_0002; s_r_data = 32'hF00D_0000;
        tick();
        check("w32_lh_ar_valid", s_ar_valid, 1);
        s_in_valid = 0;
        tick(); tick();
        check("w32_lh_out_valid", s_out_valid, 1);
        check("w32_lh_wb", s_out_wb_data, 32'hFFFF_F00D);
        check("w32_lh_err", s_out_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
